// File: rtl/mcdf_arb_pkg.sv
// mcdf_arb_pkg: shared state type, constants and helpers for the MCDF packet arbiter.
package mcdf_arb_pkg;

   // Default build configuration
   localparam int unsigned DEF_NCH = 3;
   localparam int unsigned DEF_DW  = 32;
   localparam int unsigned DEF_PW  = 2;
   localparam int unsigned DEF_LW  = 3;

   // Beat counter width: holds up to 32 beats
   localparam int unsigned CNT_W = 6;

   // Packet-level arbitration state
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_XFER  = 2'd2
   } arb_state_e;

   // Packet length code to beat count; codes beyond 3 saturate at 32 beats
   function automatic logic [CNT_W-1:0] pkglen_beats(input int unsigned code);
      logic [CNT_W-1:0] beats;
      case (code)
         32'd0:   beats = CNT_W'(4);
         32'd1:   beats = CNT_W'(8);
         32'd2:   beats = CNT_W'(16);
         default: beats = CNT_W'(32);
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/mcdf_arb_pick.sv
// mcdf_arb_pick: combinational winner selection. Lowest priority value wins;
// ties go to the requester closest to rr_ptr walking upward with wrap.
module mcdf_arb_pick
   import mcdf_arb_pkg::*;
#(
   parameter  int unsigned NCH = DEF_NCH,
   parameter  int unsigned PW  = DEF_PW,
   localparam int unsigned IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0]    req,
   input  logic [NCH*PW-1:0] prio,
   input  logic [IDW-1:0]    rr_ptr,
   output logic [IDW-1:0]    winner_c,
   output logic              any_c
);

   logic [PW-1:0] prio_arr [NCH];
   int unsigned   dist_arr [NCH];
   int unsigned   rr_val;
   logic [PW-1:0] min_prio;
   int unsigned   best_dist;

   assign rr_val = 32'(rr_ptr);
   assign any_c  = |req;

   // Per-channel priority field and rotated distance from rr_ptr
   for (genvar g = 0; g < NCH; g++) begin : g_chan
      assign prio_arr[g] = prio[g*PW +: PW];
      assign dist_arr[g] = (32'(g) >= rr_val) ? (32'(g) - rr_val)
                                              : (32'(g) + NCH - rr_val);
   end

   // Best (lowest) priority value among requesting channels
   always_comb begin
      min_prio = '1;
      for (int c = 0; c < NCH; c++) begin
         if (req[c] && (prio_arr[c] < min_prio)) begin
            min_prio = prio_arr[c];
         end
      end
   end

   // Among best-priority requesters, take the one nearest rr_ptr
   always_comb begin
      best_dist = NCH;
      winner_c  = '0;
      for (int c = 0; c < NCH; c++) begin
         if (req[c] && (prio_arr[c] == min_prio) && (dist_arr[c] < best_dist)) begin
            best_dist = dist_arr[c];
            winner_c  = IDW'(c);
         end
      end
   end

endmodule

// File: rtl/mcdf_arbiter_rr.sv
// mcdf_arbiter_rr: N-channel MCDF arbiter between slave channel FIFOs and the
// formatter. Grants one channel per packet and forwards its data for the
// packet's beat count through one registered stage.
// Optional feature macro: MCDF_ARB_RR_EN -- round-robin among equal priorities
// with rr_ptr advancing at packet end; when undefined, ties go to the lowest
// channel index.
module mcdf_arbiter_rr
   import mcdf_arb_pkg::*;
#(
   parameter  int unsigned NCH = DEF_NCH,
   parameter  int unsigned DW  = DEF_DW,
   parameter  int unsigned PW  = DEF_PW,
   parameter  int unsigned LW  = DEF_LW,
   localparam int unsigned IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [NCH*PW-1:0] slv_prio_i,
   input  logic [NCH*LW-1:0] slv_pkglen_i,
   input  logic [NCH*DW-1:0] slv_data_i,
   input  logic [NCH-1:0]    slv_req_i,
   input  logic [NCH-1:0]    slv_val_i,
   input  logic              f2a_id_req_i,
   input  logic              f2a_ack_i,
   output logic [NCH-1:0]    a2s_ack_o,
   output logic              a2f_val_o,
   output logic [IDW-1:0]    a2f_id_o,
   output logic [DW-1:0]     a2f_data_o,
   output logic [LW-1:0]     a2f_pkglen_sel_o
);

   arb_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   pick_winner_c;
   logic             pick_any_c;
   logic             win_val_c;
   logic             last_beat_c;
   logic [LW-1:0]    pkglen_arr [NCH];
   logic [DW-1:0]    data_arr   [NCH];

   // Unpack per-channel pkglen and data fields
   for (genvar g = 0; g < NCH; g++) begin : g_unpack
      assign pkglen_arr[g] = slv_pkglen_i[g*LW +: LW];
      assign data_arr[g]   = slv_data_i[g*DW +: DW];
   end

   // Winner selection for the next packet
   mcdf_arb_pick #(
      .NCH (NCH),
      .PW  (PW)
   ) u_pick (
      .req      (slv_req_i),
      .prio     (slv_prio_i),
      .rr_ptr   (rr_ptr),
      .winner_c (pick_winner_c),
      .any_c    (pick_any_c)
   );

   // Valid beat from the granted channel; the last one closes the packet
   assign win_val_c   = slv_val_i[a2f_id_o];
   assign last_beat_c = (state == ST_XFER) && win_val_c && (cnt == CNT_W'(1));

   // Packet FSM with registered grant, acknowledge and data path
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state            <= ST_IDLE;
         cnt              <= '0;
         a2s_ack_o        <= '0;
         a2f_val_o        <= 1'b0;
         a2f_id_o         <= '0;
         a2f_data_o       <= '0;
         a2f_pkglen_sel_o <= '0;
      end else begin
         a2s_ack_o <= '0;
         a2f_val_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (f2a_id_req_i && pick_any_c) begin
                  a2f_id_o         <= pick_winner_c;
                  a2f_pkglen_sel_o <= pkglen_arr[pick_winner_c];
                  state            <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (f2a_ack_i) begin
                  a2s_ack_o[a2f_id_o] <= 1'b1;
                  cnt                 <= pkglen_beats(32'(a2f_pkglen_sel_o));
                  state               <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (win_val_c) begin
                  a2f_val_o  <= 1'b1;
                  a2f_data_o <= data_arr[a2f_id_o];
                  cnt        <= cnt - CNT_W'(1);
                  if (last_beat_c) begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef MCDF_ARB_RR_EN
   // Round-robin pointer moves past the channel that just finished a packet
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rr_ptr <= '0;
      end else if (last_beat_c) begin
         rr_ptr <= (a2f_id_o == IDW'(NCH - 1)) ? '0 : (a2f_id_o + IDW'(1));
      end
   end
`else
   // Fixed tie-break start: lowest channel index
   assign rr_ptr = '0;
`endif

endmodule

// File: tb/tb_mcdf_arbiter_rr.sv
// tb_mcdf_arbiter_rr: randomized self-checking bench for mcdf_arbiter_rr.
module tb_mcdf_arbiter_rr;

   localparam int NCH = 3;
   localparam int DW  = 32;
   localparam int PW  = 2;
   localparam int LW  = 3;
   localparam int IDW = 2;
`ifdef MCDF_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rstn_i;
   logic [NCH*PW-1:0] slv_prio_i;
   logic [NCH*LW-1:0] slv_pkglen_i;
   logic [NCH*DW-1:0] slv_data_i;
   logic [NCH-1:0]    slv_req_i;
   logic [NCH-1:0]    slv_val_i;
   logic              f2a_id_req_i;
   logic              f2a_ack_i;
   logic [NCH-1:0]    a2s_ack_o;
   logic              a2f_val_o;
   logic [IDW-1:0]    a2f_id_o;
   logic [DW-1:0]     a2f_data_o;
   logic [LW-1:0]     a2f_pkglen_sel_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference state: round-robin start, granted id, packet length, last forwarded data
   int            m_rr   = 0;
   int            m_id   = 0;
   int            m_len  = 0;
   logic [DW-1:0] m_data = '0;

   mcdf_arbiter_rr #(
      .NCH (NCH),
      .DW  (DW),
      .PW  (PW),
      .LW  (LW)
   ) dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .slv_prio_i       (slv_prio_i),
      .slv_pkglen_i     (slv_pkglen_i),
      .slv_data_i       (slv_data_i),
      .slv_req_i        (slv_req_i),
      .slv_val_i        (slv_val_i),
      .f2a_id_req_i     (f2a_id_req_i),
      .f2a_ack_i        (f2a_ack_i),
      .a2s_ack_o        (a2s_ack_o),
      .a2f_val_o        (a2f_val_o),
      .a2f_id_o         (a2f_id_o),
      .a2f_data_o       (a2f_data_o),
      .a2f_pkglen_sel_o (a2f_pkglen_sel_o)
   );

   always #5 clk_i = ~clk_i;

   // Winner = smallest (priority, rotated distance from rr) pair among requesters
   function automatic int model_winner(input logic [NCH-1:0] req,
                                       input logic [NCH*PW-1:0] prio, input int rr);
      int best     = -1;
      int best_key = 0;
      int key;
      for (int c = 0; c < NCH; c++) begin
         if (req[c]) begin
            key = int'(prio[c*PW +: PW]) * NCH + ((c - rr + NCH) % NCH);
            if (best < 0 || key < best_key) begin
               best     = c;
               best_key = key;
            end
         end
      end
      return best;
   endfunction

   function automatic int model_beats(input int code);
      if (code >= 3) return 32;
      return 4 << code;
   endfunction

   function automatic int model_pkglen(input logic [NCH*LW-1:0] pl, input int id);
      return int'(pl[id*LW +: LW]);
   endfunction

   function automatic int model_next_rr(input int w);
      return RR_EN ? ((w + 1) % NCH) : 0;
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      slv_prio_i   = '0;
      slv_pkglen_i = '0;
      slv_data_i   = '0;
      slv_req_i    = '0;
      slv_val_i    = '0;
      f2a_id_req_i = 1'b0;
      f2a_ack_i    = 1'b0;
   endtask

   // Drive winner's beat plus random noise on every other channel
   task automatic set_beat(input int id, input bit v, input logic [DW-1:0] d);
      for (int c = 0; c < NCH; c++) begin
         slv_val_i[c]            = 1'($urandom_range(0, 1));
         slv_data_i[c*DW +: DW]  = $urandom;
      end
      slv_val_i[id]           = v;
      slv_data_i[id*DW +: DW] = d;
   endtask

   task automatic pulse_id_req();
      f2a_id_req_i = 1'b1;
      step();
      f2a_id_req_i = 1'b0;
   endtask

   task automatic pulse_ack();
      f2a_ack_i = 1'b1;
      step();
      f2a_ack_i = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rstn_i = 1'b0;
      step();
      step();
      total_cnt++;
      if ({a2s_ack_o, a2f_val_o, a2f_id_o, a2f_data_o, a2f_pkglen_sel_o} !== '0)
         $display("FAIL reset_outputs: got ack=%b val=%b id=%0d data=%h pkglen=%0d required all 0",
                  a2s_ack_o, a2f_val_o, a2f_id_o, a2f_data_o, a2f_pkglen_sel_o);
      else pass_cnt++;
      rstn_i = 1'b1;
      step();
      m_rr = 0;
   endtask

   task automatic test_arbitration();
      int exp_id;
      slv_prio_i   = {2'd1, 2'd1, 2'd3};
      slv_pkglen_i = {3'd2, 3'd1, 3'd0};
      slv_req_i    = '1;
      exp_id = model_winner(slv_req_i, slv_prio_i, m_rr);
      pulse_id_req();
      total_cnt++;
      if (a2f_id_o !== IDW'(exp_id))
         $display("FAIL arb_id: got %0d required %0d", a2f_id_o, exp_id);
      else pass_cnt++;
      total_cnt++;
      if (a2f_pkglen_sel_o !== LW'(model_pkglen(slv_pkglen_i, exp_id)))
         $display("FAIL arb_pkglen: got %0d required %0d", a2f_pkglen_sel_o,
                  model_pkglen(slv_pkglen_i, exp_id));
      else pass_cnt++;
      total_cnt++;
      if (a2s_ack_o !== '0)
         $display("FAIL ack_before_ack: got %b required 000", a2s_ack_o);
      else pass_cnt++;
      pulse_ack();
      total_cnt++;
      if (a2s_ack_o !== NCH'(1 << exp_id))
         $display("FAIL ack_pulse: got %b required %b", a2s_ack_o, NCH'(1 << exp_id));
      else pass_cnt++;
      step();
      total_cnt++;
      if (a2s_ack_o !== '0)
         $display("FAIL ack_one_cycle: got %b required 000", a2s_ack_o);
      else pass_cnt++;
      m_id  = exp_id;
      m_len = model_beats(model_pkglen(slv_pkglen_i, exp_id));
   endtask

   task automatic test_packet_data();
      logic [DW-1:0] d;
      for (int b = 0; b < m_len; b++) begin
         d = $urandom;
         set_beat(m_id, 1'b1, d);
         step();
         total_cnt++;
         if ({a2f_val_o, a2f_data_o} !== {1'b1, d})
            $display("FAIL beat_data[%0d]: got val=%b data=%h required val=1 data=%h",
                     b, a2f_val_o, a2f_data_o, d);
         else pass_cnt++;
         m_data = d;
      end
      m_rr = model_next_rr(m_id);
      set_beat(m_id, 1'b1, $urandom);
      step();
      total_cnt++;
      if ({a2f_val_o, a2f_data_o} !== {1'b0, m_data})
         $display("FAIL after_last_beat: got val=%b data=%h required val=0 data=%h",
                  a2f_val_o, a2f_data_o, m_data);
      else pass_cnt++;
      slv_val_i = '0;
   endtask

   task automatic test_round_robin();
      int exp_id;
      logic [DW-1:0] d;
      for (int p = 0; p < 2; p++) begin
         slv_prio_i   = {2'd1, 2'd1, 2'd3};
         slv_pkglen_i = {3'd2, 3'd1, 3'd0};
         slv_req_i    = '1;
         exp_id = model_winner(slv_req_i, slv_prio_i, m_rr);
         pulse_id_req();
         total_cnt++;
         if (a2f_id_o !== IDW'(exp_id))
            $display("FAIL rr_id[%0d]: got %0d required %0d", p, a2f_id_o, exp_id);
         else pass_cnt++;
         pulse_ack();
         total_cnt++;
         if (a2s_ack_o !== NCH'(1 << exp_id))
            $display("FAIL rr_ack[%0d]: got %b required %b", p, a2s_ack_o, NCH'(1 << exp_id));
         else pass_cnt++;
         m_len = model_beats(model_pkglen(slv_pkglen_i, exp_id));
         for (int b = 0; b < m_len; b++) begin
            d = $urandom;
            set_beat(exp_id, 1'b1, d);
            step();
            total_cnt++;
            if ({a2f_val_o, a2f_data_o} !== {1'b1, d})
               $display("FAIL rr_beat[%0d][%0d]: got val=%b data=%h required val=1 data=%h",
                        p, b, a2f_val_o, a2f_data_o, d);
            else pass_cnt++;
            m_data = d;
         end
         m_rr = model_next_rr(exp_id);
         m_id = exp_id;
         slv_val_i = '0;
      end
   endtask

   task automatic test_gap();
      int exp_id;
      bit v;
      logic [DW-1:0] d;
      slv_req_i    = 3'b001;
      slv_pkglen_i = {3'd2, 3'd1, 3'd0};
      exp_id = model_winner(slv_req_i, slv_prio_i, m_rr);
      pulse_id_req();
      total_cnt++;
      if (a2f_id_o !== IDW'(exp_id))
         $display("FAIL gap_id: got %0d required %0d", a2f_id_o, exp_id);
      else pass_cnt++;
      pulse_ack();
      // 3 beats, 2 idle cycles, final beat of a 4-beat packet, then one extra
      for (int b = 0; b < 7; b++) begin
         v = (b < 3) || (b == 5) || (b == 6);
         d = $urandom;
         set_beat(exp_id, v, d);
         step();
         if (b == 6) begin
            total_cnt++;
            if ({a2f_val_o, a2f_data_o} !== {1'b0, m_data})
               $display("FAIL gap_end: got val=%b data=%h required val=0 data=%h",
                        a2f_val_o, a2f_data_o, m_data);
            else pass_cnt++;
         end else begin
            if (v) m_data = d;
            total_cnt++;
            if ({a2f_val_o, a2f_data_o} !== {v, m_data})
               $display("FAIL gap_cycle[%0d]: got val=%b data=%h required val=%b data=%h",
                        b, a2f_val_o, a2f_data_o, v, m_data);
            else pass_cnt++;
         end
      end
      m_rr = model_next_rr(exp_id);
      m_id = exp_id;
      slv_val_i = '0;
   endtask

   task automatic test_no_request();
      int exp_id;
      logic [DW-1:0] d;
      slv_req_i = '0;
      pulse_id_req();
      step();
      total_cnt++;
      if (a2s_ack_o !== '0)
         $display("FAIL noreq_ack: got %b required 000", a2s_ack_o);
      else pass_cnt++;
      pulse_ack();
      step();
      total_cnt++;
      if ({a2s_ack_o, a2f_id_o} !== {NCH'(0), IDW'(m_id)})
         $display("FAIL idle_ack_ignored: got ack=%b id=%0d required ack=000 id=%0d",
                  a2s_ack_o, a2f_id_o, m_id);
      else pass_cnt++;
      // id_req and ack together in IDLE: arbitration only
      slv_req_i    = 3'b100;
      exp_id       = model_winner(slv_req_i, slv_prio_i, m_rr);
      f2a_id_req_i = 1'b1;
      f2a_ack_i    = 1'b1;
      step();
      f2a_id_req_i = 1'b0;
      f2a_ack_i    = 1'b0;
      total_cnt++;
      if ({a2s_ack_o, a2f_id_o} !== {NCH'(0), IDW'(exp_id)})
         $display("FAIL req_ack_together: got ack=%b id=%0d required ack=000 id=%0d",
                  a2s_ack_o, a2f_id_o, exp_id);
      else pass_cnt++;
      // id_req during GRANT is ignored
      slv_req_i = 3'b011;
      pulse_id_req();
      total_cnt++;
      if (a2f_id_o !== IDW'(exp_id))
         $display("FAIL grant_id_held: got %0d required %0d", a2f_id_o, exp_id);
      else pass_cnt++;
      pulse_ack();
      total_cnt++;
      if (a2s_ack_o !== NCH'(1 << exp_id))
         $display("FAIL grant_ack: got %b required %b", a2s_ack_o, NCH'(1 << exp_id));
      else pass_cnt++;
      m_len = model_beats(model_pkglen(slv_pkglen_i, exp_id));
      for (int b = 0; b < m_len; b++) begin
         d = $urandom;
         set_beat(exp_id, 1'b1, d);
         step();
         m_data = d;
      end
      total_cnt++;
      if ({a2f_val_o, a2f_data_o} !== {1'b1, m_data})
         $display("FAIL noreq_last_beat: got val=%b data=%h required val=1 data=%h",
                  a2f_val_o, a2f_data_o, m_data);
      else pass_cnt++;
      m_rr = model_next_rr(exp_id);
      m_id = exp_id;
      slv_val_i = '0;
   endtask

   task automatic test_reset_mid_packet();
      int exp_id;
      logic [DW-1:0] d;
      slv_prio_i   = {2'd1, 2'd1, 2'd3};
      slv_pkglen_i = {3'd2, 3'd1, 3'd0};
      slv_req_i    = 3'b010;
      exp_id = model_winner(slv_req_i, slv_prio_i, m_rr);
      pulse_id_req();
      pulse_ack();
      for (int b = 0; b < 5; b++) begin
         d = $urandom | 32'h1;
         set_beat(exp_id, 1'b1, d);
         step();
      end
      total_cnt++;
      if ({a2f_val_o, a2f_data_o} !== {1'b1, d})
         $display("FAIL pre_reset_beat: got val=%b data=%h required val=1 data=%h",
                  a2f_val_o, a2f_data_o, d);
      else pass_cnt++;
      rstn_i = 1'b0;
      #2;
      total_cnt++;
      if ({a2s_ack_o, a2f_val_o, a2f_id_o, a2f_data_o, a2f_pkglen_sel_o} !== '0)
         $display("FAIL async_reset: got ack=%b val=%b id=%0d data=%h pkglen=%0d required all 0",
                  a2s_ack_o, a2f_val_o, a2f_id_o, a2f_data_o, a2f_pkglen_sel_o);
      else pass_cnt++;
      step();
      rstn_i = 1'b1;
      m_rr   = 0;
      m_data = '0;
      slv_val_i = '0;
      step();
      slv_req_i = '1;
      exp_id = model_winner(slv_req_i, slv_prio_i, m_rr);
      pulse_id_req();
      total_cnt++;
      if (a2f_id_o !== IDW'(exp_id))
         $display("FAIL post_reset_id: got %0d required %0d", a2f_id_o, exp_id);
      else pass_cnt++;
      pulse_ack();
      m_len = model_beats(model_pkglen(slv_pkglen_i, exp_id));
      for (int b = 0; b < m_len; b++) begin
         d = $urandom;
         set_beat(exp_id, 1'b1, d);
         step();
         total_cnt++;
         if ({a2f_val_o, a2f_data_o} !== {1'b1, d})
            $display("FAIL post_reset_beat[%0d]: got val=%b data=%h required val=1 data=%h",
                     b, a2f_val_o, a2f_data_o, d);
         else pass_cnt++;
         m_data = d;
      end
      set_beat(exp_id, 1'b1, $urandom);
      step();
      total_cnt++;
      if (a2f_val_o !== 1'b0)
         $display("FAIL post_reset_end: got val=%b required 0", a2f_val_o);
      else pass_cnt++;
      m_rr = model_next_rr(exp_id);
      m_id = exp_id;
      slv_val_i = '0;
   endtask

   task automatic test_random_packets();
      int exp_id;
      int sent;
      bit v;
      logic [DW-1:0] d;
      for (int p = 0; p < 12; p++) begin
         slv_prio_i   = (NCH*PW)'($urandom);
         slv_pkglen_i = (NCH*LW)'($urandom);
         slv_req_i    = NCH'($urandom_range(1, (1 << NCH) - 1));
         exp_id = model_winner(slv_req_i, slv_prio_i, m_rr);
         m_len  = model_beats(model_pkglen(slv_pkglen_i, exp_id));
         pulse_id_req();
         total_cnt++;
         if ({a2f_id_o, a2f_pkglen_sel_o} !==
             {IDW'(exp_id), LW'(model_pkglen(slv_pkglen_i, exp_id))})
            $display("FAIL rnd_arb[%0d]: got id=%0d pkglen=%0d required id=%0d pkglen=%0d",
                     p, a2f_id_o, a2f_pkglen_sel_o, exp_id, model_pkglen(slv_pkglen_i, exp_id));
         else pass_cnt++;
         // Random wait in GRANT with noisy valids that must not be forwarded
         for (int w = 0; w < $urandom_range(0, 2); w++) begin
            set_beat(exp_id, 1'b1, $urandom);
            step();
            total_cnt++;
            if (a2f_val_o !== 1'b0)
               $display("FAIL rnd_grant_val[%0d]: got %b required 0", p, a2f_val_o);
            else pass_cnt++;
         end
         slv_val_i = '0;
         pulse_ack();
         total_cnt++;
         if (a2s_ack_o !== NCH'(1 << exp_id))
            $display("FAIL rnd_ack[%0d]: got %b required %b", p, a2s_ack_o, NCH'(1 << exp_id));
         else pass_cnt++;
         sent = 0;
         while (sent < m_len) begin
            v = ($urandom_range(0, 3) != 0);
            d = $urandom;
            slv_prio_i   = (NCH*PW)'($urandom);
            slv_pkglen_i = (NCH*LW)'($urandom);
            slv_req_i    = NCH'($urandom);
            f2a_id_req_i = 1'($urandom_range(0, 1));
            f2a_ack_i    = 1'($urandom_range(0, 1));
            set_beat(exp_id, v, d);
            step();
            if (v) begin
               m_data = d;
               sent++;
            end
            total_cnt++;
            if ({a2f_val_o, a2f_data_o} !== {v, m_data})
               $display("FAIL rnd_beat[%0d]: got val=%b data=%h required val=%b data=%h",
                        p, a2f_val_o, a2f_data_o, v, m_data);
            else pass_cnt++;
         end
         f2a_id_req_i = 1'b0;
         f2a_ack_i    = 1'b0;
         set_beat(exp_id, 1'b1, $urandom);
         step();
         total_cnt++;
         if ({a2f_val_o, a2s_ack_o} !== {1'b0, NCH'(0)})
            $display("FAIL rnd_end[%0d]: got val=%b ack=%b required val=0 ack=000",
                     p, a2f_val_o, a2s_ack_o);
         else pass_cnt++;
         m_rr = model_next_rr(exp_id);
         m_id = exp_id;
         slv_val_i = '0;
      end
   endtask

   initial begin
      test_reset();
      test_arbitration();
      test_packet_data();
      test_round_robin();
      test_gap();
      test_no_request();
      test_reset_mid_packet();
      test_random_packets();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
